// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, FSM state encoding and round helper functions.
// Imported by the sequencer top and the message-schedule sub-module.
package sha1_pkg;

    localparam logic [31:0] K0 = 32'h5A827999;
    localparam logic [31:0] K1 = 32'h6ED9EBA1;
    localparam logic [31:0] K2 = 32'h8F1BBCDC;
    localparam logic [31:0] K3 = 32'hCA62C1D6;

    localparam logic [31:0] IV0_DEF = 32'h67452301;
    localparam logic [31:0] IV1_DEF = 32'hEFCDAB89;
    localparam logic [31:0] IV2_DEF = 32'h98BADCFE;
    localparam logic [31:0] IV3_DEF = 32'h10325476;
    localparam logic [31:0] IV4_DEF = 32'hC3D2E1F0;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    typedef enum logic [1:0] {
        F_CH   = 2'd0,
        F_PAR1 = 2'd1,
        F_MAJ  = 2'd2,
        F_PAR3 = 2'd3
    } fsel_t;

    function automatic fsel_t t_to_fsel(input logic [6:0] t);
        if (t < 7'd20)      return F_CH;
        else if (t < 7'd40) return F_PAR1;
        else if (t < 7'd60) return F_MAJ;
        else                return F_PAR3;
    endfunction

    function automatic logic [31:0] fsel_k(input fsel_t s);
        case (s)
            F_CH:    return K0;
            F_PAR1:  return K1;
            F_MAJ:   return K2;
            default: return K3;
        endcase
    endfunction

    function automatic logic [31:0] f0(input logic [31:0] b, c, d);
        return (b & c) | (~b & d);
    endfunction

    function automatic logic [31:0] f1(input logic [31:0] b, c, d);
        return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] f2(input logic [31:0] b, c, d);
        return (b & c) | (b & d) | (c & d);
    endfunction

    function automatic logic [31:0] f3(input logic [31:0] b, c, d);
        return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] add_32(input logic [31:0] x, y);
        return x + y;
    endfunction

    function automatic logic [31:0] left_rotate1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] left_rotate5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic logic [31:0] left_rotate30(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

    function automatic logic [31:0] w_expand(input logic [31:0] w3, w8, w14, w16);
        return left_rotate1(w3 ^ w8 ^ w14 ^ w16);
    endfunction

endpackage

// File: rtl/sha1_round_ctrl_if.sv
// Block-in / digest-out handshake bundle for the SHA-1 round sequencer.
// master = padder/consumer side, slave = sequencer side.
interface sha1_round_ctrl_if;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         digest_valid;
    logic         digest_ready;
    logic [159:0] digest;
    logic         busy;
    logic [6:0]   round;

    modport master (
        output blk_valid, blk_data, blk_first, digest_ready,
        input  blk_ready, digest_valid, digest, busy, round
    );

    modport slave (
        input  blk_valid, blk_data, blk_first, digest_ready,
        output blk_ready, digest_valid, digest, busy, round
    );
endinterface

// File: rtl/sha1_w_sched.sv
// SHA-1 message schedule: 16-word circular buffer loaded from the block,
// expanded in place so only the last 16 W values are ever stored.
module sha1_w_sched
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [511:0] load_data,
    input  logic         step,
    input  logic [6:0]   t,
    output logic [31:0]  w_t
);

    logic [15:0][31:0] wbuf_q, wbuf_d;
    logic [3:0]        idx, i3, i8, i14;
    logic [31:0]       w_exp;

    always_comb begin
        idx   = t[3:0];
        i3    = idx - 4'd3;
        i8    = idx - 4'd8;
        i14   = idx - 4'd14;
        w_exp = w_expand(wbuf_q[i3], wbuf_q[i8], wbuf_q[i14], wbuf_q[idx]);
        w_t   = (t < 7'd16) ? wbuf_q[idx] : w_exp;

        wbuf_d = wbuf_q;
        if (load) begin
            // word 0 sits in the top bits of the block
            for (int i = 0; i < 16; i++) begin
                wbuf_d[i] = load_data[511 - 32*i -: 32];
            end
        end else if (step && (t >= 7'd16)) begin
            wbuf_d[idx] = w_exp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbuf_q <= '0;
        end else begin
            wbuf_q <= wbuf_d;
        end
    end

endmodule

// File: rtl/sha1_round_ctrl.sv
// SHA-1 compression sequencer: one 512-bit block per handshake, one round per clock,
// chaining value held in H. Optional `abort` input when SHA1_ABORT_EN is defined.
module sha1_round_ctrl
    import sha1_pkg::*;
#(
    parameter logic [31:0] IV0 = IV0_DEF,
    parameter logic [31:0] IV1 = IV1_DEF,
    parameter logic [31:0] IV2 = IV2_DEF,
    parameter logic [31:0] IV3 = IV3_DEF,
    parameter logic [31:0] IV4 = IV4_DEF
) (
    input  logic clk,
    input  logic rst,
`ifdef SHA1_ABORT_EN
    input  logic abort,
`endif
    sha1_round_ctrl_if.slave bus
);

    localparam logic [159:0] IV_VEC = {IV0, IV1, IV2, IV3, IV4};

    state_t            state_q, state_d;
    logic [6:0]        t_q, t_d;
    logic [31:0]       a_q, b_q, c_q, d_q, e_q;
    logic [31:0]       a_d, b_d, c_d, d_d, e_d;
    // h_q[4] is H0 so the packed vector lines up directly with the digest port
    logic [4:0][31:0]  h_q, h_d;

    logic              w_load, w_step, abort_hit;
    logic [31:0]       w_t, f_val, k_val, temp;
    fsel_t             fsel;

`ifdef SHA1_ABORT_EN
    assign abort_hit = abort & (state_q != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    sha1_w_sched u_w_sched (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .load_data (bus.blk_data),
        .step      (w_step),
        .t         (t_q),
        .w_t       (w_t)
    );

    assign bus.blk_ready    = (state_q == IDLE);
    assign bus.digest_valid = (state_q == DONE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.round        = t_q;
    assign bus.digest       = h_q;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        e_d     = e_q;
        h_d     = h_q;
        w_load  = 1'b0;
        w_step  = 1'b0;

        fsel  = t_to_fsel(t_q);
        k_val = fsel_k(fsel);
        unique case (fsel)
            F_CH:   f_val = f0(b_q, c_q, d_q);
            F_PAR1: f_val = f1(b_q, c_q, d_q);
            F_MAJ:  f_val = f2(b_q, c_q, d_q);
            F_PAR3: f_val = f3(b_q, c_q, d_q);
        endcase
        temp = add_32(add_32(add_32(left_rotate5(a_q), f_val), add_32(e_q, k_val)), w_t);

        unique case (state_q)
            IDLE: begin
                if (bus.blk_valid) begin
                    state_d = ROUND;
                    t_d     = 7'd0;
                    w_load  = 1'b1;
                    if (bus.blk_first) begin
                        h_d = IV_VEC;
                        {a_d, b_d, c_d, d_d, e_d} = IV_VEC;
                    end else begin
                        {a_d, b_d, c_d, d_d, e_d} = h_q;
                    end
                end
            end
            ROUND: begin
                w_step = 1'b1;
                e_d    = d_q;
                d_d    = c_q;
                c_d    = left_rotate30(b_q);
                b_d    = a_q;
                a_d    = temp;
                // round holds at 79 until the next block is accepted
                if (t_q == 7'd79) state_d = FINAL;
                else              t_d     = t_q + 7'd1;
            end
            FINAL: begin
                h_d = {add_32(h_q[4], a_q), add_32(h_q[3], b_q), add_32(h_q[2], c_q),
                       add_32(h_q[1], d_q), add_32(h_q[0], e_q)};
                state_d = DONE;
            end
            DONE: begin
                if (bus.digest_ready) state_d = IDLE;
            end
        endcase

        if (abort_hit) begin
            state_d = IDLE;
            h_d     = IV_VEC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= 7'd0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            h_q     <= IV_VEC;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
            h_q     <= h_d;
        end
    end

endmodule

// File: tb/tb_sha1_round_ctrl.sv
// Directed bench for sha1_round_ctrl using known SHA-1 vectors.
// Exercises the abort path too when built with SHA1_ABORT_EN.
module tb_sha1_round_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef SHA1_ABORT_EN
    logic abort = 1'b0;
`endif

    sha1_round_ctrl_if bus_if ();

    sha1_round_ctrl dut (
        .clk   (clk),
        .rst   (rst),
`ifdef SHA1_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [159:0] IV_EXP    = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam logic [159:0] ABC_EXP   = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
    localparam logic [159:0] EMPTY_EXP = 160'hDA39A3EE_5E6B4B0D_3255BFEF_95601890_AFD80709;
    localparam logic [159:0] TWO_EXP   = 160'h84983E44_1C3BD26E_BAAE4AA1_F95129E5_E54670F1;

    logic [511:0] blk_abc, blk_empty, blk_two0, blk_two1;

    task automatic start_block(input logic [511:0] data, input logic first, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus_if.blk_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus_if.blk_data  = data;
        bus_if.blk_first = first;
        bus_if.blk_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.blk_valid = 1'b0;
    endtask

    task automatic wait_digest(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (bus_if.digest_valid === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic ack_digest();
        bus_if.digest_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.digest_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus_if.blk_ready !== 1'b1) begin errors++; $display("FAIL reset_blk_ready got %b want 1", bus_if.blk_ready); end
        checks++; if (bus_if.digest_valid !== 1'b0) begin errors++; $display("FAIL reset_digest_valid got %b want 0", bus_if.digest_valid); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus_if.busy); end
        checks++; if (bus_if.round !== 7'd0) begin errors++; $display("FAIL reset_round got %0d want 0", bus_if.round); end
        checks++; if (bus_if.digest !== IV_EXP) begin errors++; $display("FAIL reset_digest got %h want %h", bus_if.digest, IV_EXP); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abc();
        bit ok; int cyc;
        start_block(blk_abc, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abc_accept got not-ready want ready"); end
        checks++; if (bus_if.busy !== 1'b1 || bus_if.blk_ready !== 1'b0) begin errors++; $display("FAIL abc_busy got busy=%b ready=%b want 1/0", bus_if.busy, bus_if.blk_ready); end
        wait_digest(cyc);
        checks++; if (cyc != 81) begin errors++; $display("FAIL abc_latency got %0d want 81", cyc); end
        checks++; if (bus_if.digest !== ABC_EXP) begin errors++; $display("FAIL abc_digest got %h want %h", bus_if.digest, ABC_EXP); end
        ack_digest();
        checks++; if (bus_if.digest_valid !== 1'b0 || bus_if.blk_ready !== 1'b1) begin errors++; $display("FAIL abc_release got valid=%b ready=%b want 0/1", bus_if.digest_valid, bus_if.blk_ready); end
    endtask

    task automatic test_empty();
        bit ok; int cyc;
        start_block(blk_empty, 1'b1, ok);
        wait_digest(cyc);
        checks++; if (!ok || cyc != 81) begin errors++; $display("FAIL empty_latency got ok=%0d cyc=%0d want 1/81", ok, cyc); end
        checks++; if (bus_if.digest !== EMPTY_EXP) begin errors++; $display("FAIL empty_digest got %h want %h", bus_if.digest, EMPTY_EXP); end
        ack_digest();
    endtask

    task automatic test_two_block();
        bit ok; int cyc;
        start_block(blk_two0, 1'b1, ok);
        wait_digest(cyc);
        checks++; if (!ok || cyc != 81) begin errors++; $display("FAIL two_blk0_latency got ok=%0d cyc=%0d want 1/81", ok, cyc); end
        ack_digest();
        start_block(blk_two1, 1'b0, ok);
        wait_digest(cyc);
        checks++; if (!ok || cyc != 81) begin errors++; $display("FAIL two_blk1_latency got ok=%0d cyc=%0d want 1/81", ok, cyc); end
        checks++; if (bus_if.digest !== TWO_EXP) begin errors++; $display("FAIL two_digest got %h want %h", bus_if.digest, TWO_EXP); end
        ack_digest();
    endtask

    task automatic test_hold_done();
        bit ok; int cyc;
        start_block(blk_empty, 1'b1, ok);
        wait_digest(cyc);
        checks++; if (cyc != 81) begin errors++; $display("FAIL hold_latency got %0d want 81", cyc); end
        for (int i = 0; i < 10; i++) begin
            bus_if.blk_valid = (i % 2 == 0);
            bus_if.blk_data  = blk_abc;
            bus_if.blk_first = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (bus_if.digest_valid !== 1'b1 || bus_if.blk_ready !== 1'b0 || bus_if.digest !== EMPTY_EXP) begin
                errors++;
                $display("FAIL hold_cycle%0d got valid=%b ready=%b digest=%h want 1/0/%h", i, bus_if.digest_valid, bus_if.blk_ready, bus_if.digest, EMPTY_EXP);
            end
        end
        bus_if.blk_valid = 1'b0;
        ack_digest();
        @(posedge clk); #1;
        checks++; if (bus_if.busy !== 1'b0 || bus_if.digest !== EMPTY_EXP) begin errors++; $display("FAIL hold_after got busy=%b digest=%h want 0/%h", bus_if.busy, bus_if.digest, EMPTY_EXP); end
    endtask

    task automatic test_reset_mid();
        bit ok; bit hit; int cyc;
        start_block(blk_empty, 1'b1, ok);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus_if.round === 7'd40 && bus_if.busy === 1'b1) begin hit = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach40 got round=%0d want 40", bus_if.round); end
        rst = 1'b1;
        #1;
        checks++;
        if (bus_if.blk_ready !== 1'b1 || bus_if.digest_valid !== 1'b0 || bus_if.busy !== 1'b0 ||
            bus_if.round !== 7'd0 || bus_if.digest !== IV_EXP) begin
            errors++;
            $display("FAIL rstmid_outputs got ready=%b valid=%b busy=%b round=%0d digest=%h want 1/0/0/0/%h",
                     bus_if.blk_ready, bus_if.digest_valid, bus_if.busy, bus_if.round, bus_if.digest, IV_EXP);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_if.digest_valid !== 1'b0 || bus_if.busy !== 1'b0) begin errors++; $display("FAIL rstmid_held got valid=%b busy=%b want 0/0", bus_if.digest_valid, bus_if.busy); end
        rst = 1'b0;
        @(posedge clk); #1;
        // blk_first=0 right after reset must still chain from IV
        start_block(blk_abc, 1'b0, ok);
        wait_digest(cyc);
        checks++; if (!ok || cyc != 81) begin errors++; $display("FAIL rstmid_latency got ok=%0d cyc=%0d want 1/81", ok, cyc); end
        checks++; if (bus_if.digest !== ABC_EXP) begin errors++; $display("FAIL rstmid_digest got %h want %h", bus_if.digest, ABC_EXP); end
        ack_digest();
    endtask

`ifdef SHA1_ABORT_EN
    task automatic test_abort();
        bit ok; bit hit; bit rose; int cyc;
        start_block(blk_abc, 1'b1, ok);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus_if.round === 7'd10 && bus_if.busy === 1'b1) begin hit = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL abort_reach10 got round=%0d want 10", bus_if.round); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (bus_if.busy !== 1'b0 || bus_if.blk_ready !== 1'b1 || bus_if.digest !== IV_EXP) begin errors++; $display("FAIL abort_idle got busy=%b ready=%b digest=%h want 0/1/%h", bus_if.busy, bus_if.blk_ready, bus_if.digest, IV_EXP); end
        rose = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus_if.digest_valid !== 1'b0) rose = 1'b1;
        end
        checks++; if (rose) begin errors++; $display("FAIL abort_no_valid got rose=1 want 0"); end
        start_block(blk_empty, 1'b1, ok);
        wait_digest(cyc);
        checks++; if (!ok || cyc != 81) begin errors++; $display("FAIL abort_next_latency got ok=%0d cyc=%0d want 1/81", ok, cyc); end
        checks++; if (bus_if.digest !== EMPTY_EXP) begin errors++; $display("FAIL abort_next_digest got %h want %h", bus_if.digest, EMPTY_EXP); end
        ack_digest();
    endtask
`endif

    initial begin
        bus_if.blk_valid    = 1'b0;
        bus_if.blk_data     = '0;
        bus_if.blk_first    = 1'b0;
        bus_if.digest_ready = 1'b0;

        blk_abc   = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
        blk_empty = {32'h80000000, {15{32'h00000000}}};
        blk_two0  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                     32'h65666768, 32'h66676869, 32'h6768696A, 32'h68696A6B,
                     32'h696A6B6C, 32'h6A6B6C6D, 32'h6B6C6D6E, 32'h6C6D6E6F,
                     32'h6D6E6F70, 32'h6E6F7071, 32'h80000000, 32'h00000000};
        blk_two1  = {{15{32'h00000000}}, 32'h000001C0};

        test_reset();
        test_abc();
        test_empty();
        test_two_block();
        test_hold_done();
        test_reset_mid();
`ifdef SHA1_ABORT_EN
        test_abort();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha1_round_ctrl.md
# sha1_round_ctrl

Sequencer for the SHA-1 compression datapath. Accepts one padded 512-bit message block per handshake and runs the 80 rounds at one round per clock. It generates the message schedule W, selects the f0/f1/f2/f3 function and K constant per round, and accumulates the chaining value H. The block sits between the message padder (upstream) and the digest consumer (downstream).

## Interface
Parameters:
- IV0 — 32'h67452301 — initial H0
- IV1 — 32'hEFCDAB89 — initial H1
- IV2 — 32'h98BADCFE — initial H2
- IV3 — 32'h10325476 — initial H3
- IV4 — 32'hC3D2E1F0 — initial H4

Ports:
- clk  in  1  — sole clock, rising edge
- rst  in  1  — asynchronous, active-high reset
- blk_valid  in  1  — block offered
- blk_ready  out  1  — block can be accepted
- blk_data  in  512  — word 0 at [511:480], big-endian words
- blk_first  in  1  — sampled with the block; 1 = start a new message (chain from IV)
- digest_valid  out  1  — digest available
- digest_ready  in  1  — consumer accepts the digest
- digest  out  160  — H0 at [159:128] down to H4 at [31:0]
- busy  out  1  — high in every state except IDLE
- round  out  7  — current round index t, 0..79

## Operation
- States and transitions:
  - IDLE → ROUND when blk_valid & blk_ready.
  - ROUND → FINAL after t=79.
  - FINAL → DONE.
  - DONE → IDLE when digest_ready.
- blk_ready = (state==IDLE). blk_valid outside IDLE is ignored.
- On accept:
  - W buffer[0..15] ← blk_data words; t ← 0.
  - If blk_first=1: H ← IV; a..e ← IV0..IV4.
  - Otherwise: a..e ← H0..H4.
- ROUND, each cycle:
  - W_t = buf[t] for t<16.
  - Otherwise W_t = rotl1(buf[(t-3)&15] ^ buf[(t-8)&15] ^ buf[(t-14)&15] ^ buf[t&15]), written back to buf[t&15].
  - f and K by t:
    - 0–19: Ch, K=5A827999.
    - 20–39: parity, K=6ED9EBA1.
    - 40–59: Maj, K=8F1BBCDC.
    - 60–79: parity, K=CA62C1D6.
  - temp = rotl5(a)+f(b,c,d)+e+K+W_t mod 2^32.
  - Register update: e←d, d←c, c←rotl30(b), b←a, a←temp; t←t+1.
- FINAL: Hi ← Hi + (a,b,c,d,e)i, each mod 2^32 with carries discarded.
- DONE: digest_valid=1. digest and digest_valid stay stable until digest_ready.
- digest always shows H; it changes only in FINAL and at reset/IV load.

## Timing
- Acceptance edge E. Round t executes on edge E+1+t. H updates on edge E+81. digest_valid is high from edge E+81 until the edge where digest_ready=1.
- Minimum block-to-block period is 83 cycles: IDLE costs one cycle.
- Reset values: blk_ready=1, digest_valid=0, busy=0, round=0, digest={IV0..IV4}. a..e and W buffer are 0.
- Reset mid-operation aborts the block: H ← IV, state ← IDLE, and no digest_valid is produced.
- digest_ready outside DONE has no effect.
- blk_first=0 on the very first block after reset chains from IV, since H holds IV after reset.

## Configuration
- SHA1_ABORT_EN defined: adds input abort (1 bit).
  - abort=1 in ROUND, FINAL or DONE → next edge state ← IDLE, H ← IV, digest_valid ← 0.
  - abort is ignored in IDLE.
- SHA1_ABORT_EN undefined: the port and its logic are absent.

## Structure
- Package sha1_pkg holds:
  - K0..K3 constants
  - default IV constants
  - state enum: IDLE, ROUND, FINAL, DONE
  - 2-bit f-select encoding and the t→f-select function
- Sub-module sha1_w_sched: 16×32 circular buffer, load port, and expansion built on w_expand. Outputs W_t for the current t.
- The round datapath reuses f0–f3, add_32, left_rotate5 and left_rotate30.

## Test plan
- "abc" padded block, blk_first=1 → digest A9993E36 4706816A BA3E2571 7850C26C 9CD0D89D; digest_valid asserted exactly 81 edges after accept.
- Empty-message padded block, blk_first=1 → DA39A3EE 5E6B4B0D 3255BFEF 95601890 AFD80709.
- 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" as two blocks, blk_first=1 then 0 → 84983E44 1C3BD26E BAAE4AA1 F95129E5 E54670F1.
- Hold digest_ready=0 for 10 cycles in DONE while toggling blk_valid → digest/digest_valid stable, blk_ready=0, no block accepted.
- Assert rst at round=40, release, send "abc" → all outputs at reset values during rst; next digest A9993E36… correct.
- With SHA1_ABORT_EN: abort at round=10 → IDLE next edge, digest_valid never rises; following empty-message block gives DA39A3EE… correct.
